// File: rtl/sump_pkg.sv
// Shared SUMP protocol definitions: decoder states, opcode values and the published command record.
package sump_pkg;

  typedef enum logic {IDLE, ARG} dec_state_t;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_RUN       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_META      = 8'h04;
  localparam logic [7:0] OP_XON       = 8'h11;
  localparam logic [7:0] OP_XOFF      = 8'h13;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;
  localparam logic [7:0] OP_TRIG_MASK = 8'hC0;
  localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;
  localparam logic [7:0] OP_TRIG_CFG  = 8'hC2;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] data;
    logic        is_long;
  } sump_cmd_t;

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Byte stream in from the UART receiver and decoded command strobe out to the sniffer core.
interface sump_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic [7:0]  opcode;
  logic [31:0] cmd_data;
  logic        cmd_long;
  logic        cmd_reset;
  logic        cmd_abort;

  modport master (
    output rx_data, rx_valid,
    input  cmd_valid, opcode, cmd_data, cmd_long, cmd_reset, cmd_abort
  );

  modport slave (
    input  rx_data, rx_valid,
    output cmd_valid, opcode, cmd_data, cmd_long, cmd_reset, cmd_abort
  );
endinterface

// File: rtl/sump_cmd_decoder.sv
// Assembles UART bytes into short/long SUMP commands, one registered strobe per command,
// and drops a stalled long command after TIMEOUT_CYCLES idle cycles.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  sump_cmd_decoder_if.slave     bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES - 1);

  dec_state_t     state, state_nxt;
  logic [1:0]     idx;
  logic [CW-1:0]  tmo;
  logic [7:0]     op_lat;
  logic [31:0]    shreg;
  sump_cmd_t      cmd_q;
  logic           valid_q, reset_q, abort_q;
  logic           fire_short, fire_long, expire;

  always_comb begin
    state_nxt  = state;
    fire_short = 1'b0;
    fire_long  = 1'b0;
    expire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7]) state_nxt = ARG;
          else                fire_short = 1'b1;
        end
      end
      ARG: begin
        // A byte arriving in the expiry cycle takes priority over the abort
        if (bus.rx_valid) begin
          if (idx == 2'd3) begin
            fire_long = 1'b1;
            state_nxt = IDLE;
          end
        end else if (tmo == TMO_MAX) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      tmo     <= '0;
      op_lat  <= '0;
      shreg   <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      reset_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= fire_short | fire_long;
      reset_q <= fire_short && (bus.rx_data == OP_RESET);
      abort_q <= expire;

      if (state == IDLE) begin
        idx <= '0;
        tmo <= '0;
        if (bus.rx_valid && bus.rx_data[7]) begin
          op_lat <= bus.rx_data;
          shreg  <= '0;
        end
      end else if (bus.rx_valid) begin
        unique case (idx)
          2'd0: shreg[7:0]   <= bus.rx_data;
          2'd1: shreg[15:8]  <= bus.rx_data;
          2'd2: shreg[23:16] <= bus.rx_data;
          2'd3: shreg[31:24] <= bus.rx_data;
          default: ;
        endcase
        idx <= idx + 2'd1;
        tmo <= '0;
      end else if (expire) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + CW'(1);
      end

      if (fire_short) begin
        cmd_q.op      <= bus.rx_data;
        cmd_q.data    <= '0;
        cmd_q.is_long <= 1'b0;
      end else if (fire_long) begin
        cmd_q.op      <= op_lat;
        cmd_q.data    <= {bus.rx_data, shreg[23:0]};
        cmd_q.is_long <= 1'b1;
      end
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_reset = reset_q;
  assign bus.cmd_abort = abort_q;
  assign bus.opcode    = cmd_q.op;
  assign bus.cmd_data  = cmd_q.data;
  assign bus.cmd_long  = cmd_q.is_long;

endmodule
